// File: rtl/matrix_led_scanner.sv
// Double-buffered row-multiplexed LED matrix scanner with per-row blanking
// and brightness expressed as lit cycles within each row's ON phase.
module matrix_led_scanner #(
    parameter int unsigned ROWS           = 8,
    parameter int unsigned COLS           = 8,
    parameter int unsigned ROW_W          = $clog2(ROWS),
    parameter int unsigned DWELL          = 33750,
    parameter int unsigned BLANK          = 64,
    parameter int unsigned BRIGHT_W       = 4,
    parameter int unsigned COL_ACTIVE_LOW = 0
) (
    input  logic                sys_clock,
    input  logic                sys_rst_n,
    input  logic                wr_en,
    input  logic [ROW_W-1:0]    wr_row,
    input  logic [COLS-1:0]     wr_data,
    input  logic                swap_req,
    input  logic [BRIGHT_W-1:0] brightness,
    output logic [ROW_W-1:0]    row,
    output logic [COLS-1:0]     col,
    output logic                frame_start,
    output logic                swap_ack
);

    typedef enum logic {ST_BLANK, ST_ON} state_t;

    localparam int unsigned    STEP    = DWELL >> BRIGHT_W;
    localparam logic [COLS-1:0] COL_OFF = {COLS{1'(COL_ACTIVE_LOW != 0)}};

    state_t            state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [31:0]       thr_q, thr_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COLS-1:0]   col_q, col_d;
    logic              frame_start_q, frame_start_d;
    logic              swap_ack_q, swap_ack_d;
    logic              pend_q, pend_d;
    logic              bank_q, bank_d;
    logic [COLS-1:0]   mem_q [2][ROWS];
    logic [COLS-1:0]   mem_d [2][ROWS];
    logic [COLS-1:0]   front_row;

    assign front_row = mem_q[bank_q][row_q];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + 32'd1;
        thr_d         = thr_q;
        row_d         = row_q;
        bank_d        = bank_q;
        pend_d        = pend_q | swap_req;
        frame_start_d = 1'b0;
        swap_ack_d    = 1'b0;
        col_d         = COL_OFF;
        mem_d         = mem_q;

        // Writes target the current back bank, so a write coinciding with a
        // swap lands in the bank that is about to become front.
        if (wr_en && (32'(wr_row) < ROWS)) begin
            mem_d[~bank_q][wr_row] = wr_data;
        end

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK - 1) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                    thr_d   = (brightness == '1) ? DWELL : STEP * 32'(brightness);
                end
            end
            ST_ON: begin
                if (cnt_q == DWELL - 1) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    if (row_q == ROW_W'(ROWS - 1)) begin
                        row_d         = '0;
                        frame_start_d = 1'b1;
                        if (pend_q || swap_req) begin
                            bank_d     = ~bank_q;
                            pend_d     = 1'b0;
                            swap_ack_d = 1'b1;
                        end
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            default: state_d = ST_BLANK;
        endcase

        // Row never changes while the next state is ON, so front_row is the
        // data for the row being lit next cycle.
        if (state_d == ST_ON && cnt_d < thr_d) begin
            col_d = front_row ^ COL_OFF;
        end
    end

    always_ff @(posedge sys_clock) begin
        if (!sys_rst_n) begin
            state_q       <= ST_BLANK;
            cnt_q         <= '0;
            thr_q         <= '0;
            row_q         <= '0;
            col_q         <= COL_OFF;
            frame_start_q <= 1'b0;
            swap_ack_q    <= 1'b0;
            pend_q        <= 1'b0;
            bank_q        <= 1'b0;
            mem_q         <= '{default: '0};
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            thr_q         <= thr_d;
            row_q         <= row_d;
            col_q         <= col_d;
            frame_start_q <= frame_start_d;
            swap_ack_q    <= swap_ack_d;
            pend_q        <= pend_d;
            bank_q        <= bank_d;
            mem_q         <= mem_d;
        end
    end

    assign row         = row_q;
    assign col         = col_q;
    assign frame_start = frame_start_q;
    assign swap_ack    = swap_ack_q;

endmodule

// File: tb/tb_matrix_led_scanner.sv
// Self-checking bench: a cycle-position model (time since reset modulo the
// row/frame period) predicts row, col, frame_start and swap_ack every cycle.
module tb_matrix_led_scanner;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int DWELL = 16;
    localparam int BLANK = 2;
    localparam int BW    = 2;
    localparam int RP    = BLANK + DWELL;
    localparam int FP    = ROWS * RP;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [1:0]    wr_row = '0;
    logic [3:0]    wr_data = '0;
    logic          swap_req = 1'b0;
    logic [BW-1:0] brightness = 2'd3;

    logic [1:0] row, row_n;
    logic [3:0] col, col_n;
    logic       fs, fs_n, ack, ack_n;

    int checks = 0;
    int failures = 0;

    matrix_led_scanner #(.ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .BLANK(BLANK),
                         .BRIGHT_W(BW), .COL_ACTIVE_LOW(0)) dut (
        .sys_clock(clk), .sys_rst_n(rst_n), .wr_en(wr_en), .wr_row(wr_row),
        .wr_data(wr_data), .swap_req(swap_req), .brightness(brightness),
        .row(row), .col(col), .frame_start(fs), .swap_ack(ack));

    matrix_led_scanner #(.ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .BLANK(BLANK),
                         .BRIGHT_W(BW), .COL_ACTIVE_LOW(1)) dut_n (
        .sys_clock(clk), .sys_rst_n(rst_n), .wr_en(wr_en), .wr_row(wr_row),
        .wr_data(wr_data), .swap_req(swap_req), .brightness(brightness),
        .row(row_n), .col(col_n), .frame_start(fs_n), .swap_ack(ack_n));

    always #5 clk = ~clk;

    // Reference model: k counts edges since reset; position within the row
    // and frame follows from plain division/modulo.
    int unsigned m_k = 0;
    int unsigned m_thr = 0;
    logic [3:0]  m_bank [2][4] = '{default: '0};
    bit          m_sel = 1'b0;
    bit          m_pend = 1'b0;
    logic [1:0]  exp_row = '0;
    logic [3:0]  exp_col = '0;
    logic        exp_fs = 1'b0;
    logic        exp_ack = 1'b0;
    logic [14:0] got, want;

    always @(posedge clk) begin
        int unsigned ph;
        if (!rst_n) begin
            m_k = 0; m_thr = 0; m_sel = 0; m_pend = 0;
            m_bank = '{default: '0};
            exp_fs = 0; exp_ack = 0;
        end else begin
            if (wr_en && int'(wr_row) < ROWS) m_bank[!m_sel][wr_row] = wr_data;
            exp_fs  = ((m_k + 1) % FP == 0);
            exp_ack = exp_fs && (m_pend || swap_req);
            if (exp_ack) begin
                m_sel  = !m_sel;
                m_pend = 0;
            end else begin
                m_pend = m_pend || swap_req;
            end
            if ((m_k + 1) % RP == BLANK)
                m_thr = (brightness == 2'd3) ? DWELL : (DWELL >> BW) * int'(brightness);
            m_k++;
        end
        ph      = m_k % RP;
        exp_row = 2'((m_k / RP) % ROWS);
        exp_col = (ph >= BLANK && ph - BLANK < m_thr) ? m_bank[m_sel][exp_row] : 4'h0;
    end

    task automatic wait_frame(input string name);
        int i;
        for (i = 0; i < 2 * FP && fs !== 1'b1; i++) @(negedge clk);
        checks++;
        if (fs !== 1'b1) begin
            failures++;
            $display("FAIL %s_wait_frame: frame_start=%b required 1 within %0d cycles", name, fs, 2 * FP);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({row, col, fs, ack} !== 10'b0) begin
            failures++;
            $display("FAIL reset_state: got row=%0d col=%h fs=%b ack=%b required 0/0/0/0", row, col, fs, ack);
        end
        checks++;
        if (col_n !== 4'hF || row_n !== 2'd0 || fs_n !== 1'b0 || ack_n !== 1'b0) begin
            failures++;
            $display("FAIL reset_active_low: got row=%0d col=%h required row=0 col=f", row_n, col_n);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        int last = -1;
        brightness = 2'd3;
        for (int i = 0; i < 2 * FP + 4; i++) begin
            @(negedge clk);
            got  = {row, col, fs, ack, col_n};
            want = {exp_row, exp_col, exp_fs, exp_ack, ~exp_col};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL scan cyc=%0d: got=%h required=%h", i, got, want);
            end
            if (fs === 1'b1) begin
                checks++;
                if (i != ((last < 0) ? FP - 1 : last + FP)) begin
                    failures++;
                    $display("FAIL scan_frame_period: pulse at cyc %0d required %0d", i, (last < 0) ? FP - 1 : last + FP);
                end
                last = i;
            end
        end
    endtask

    task automatic test_swap();
        int acks = 0;
        for (int i = 0; i < 2 * FP; i++) begin
            wr_en    = (i < 4);
            wr_row   = 2'(i);
            wr_data  = 4'(1 << (i % 4));
            swap_req = (i == 10);
            @(negedge clk);
            got  = {row, col, fs, ack, col_n};
            want = {exp_row, exp_col, exp_fs, exp_ack, ~exp_col};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL swap cyc=%0d: got=%h required=%h", i, got, want);
            end
            if (ack === 1'b1) begin
                acks++;
                checks++;
                if (fs !== 1'b1) begin
                    failures++;
                    $display("FAIL swap_ack_align: frame_start=%b required 1", fs);
                end
            end
        end
        wr_en = 1'b0; swap_req = 1'b0;
        checks++;
        if (acks != 1) begin
            failures++;
            $display("FAIL swap_ack_count: got %0d required 1", acks);
        end
    endtask

    task automatic test_brightness();
        int lit;
        logic [1:0] levels [3] = '{2'd1, 2'd2, 2'd0};
        for (int l = 0; l < 3; l++) begin
            wait_frame("brightness");
            brightness = levels[l];
            lit = 0;
            for (int i = 0; i < FP; i++) begin
                @(negedge clk);
                got  = {row, col, fs, ack, col_n};
                want = {exp_row, exp_col, exp_fs, exp_ack, ~exp_col};
                checks++;
                if (got !== want) begin
                    failures++;
                    $display("FAIL brightness%0d cyc=%0d: got=%h required=%h", levels[l], i, got, want);
                end
                if (col !== 4'h0) lit++;
            end
            checks++;
            if (lit != ROWS * 4 * int'(levels[l])) begin
                failures++;
                $display("FAIL brightness%0d_lit: got %0d lit cycles required %0d", levels[l], lit, ROWS * 4 * int'(levels[l]));
            end
        end
        // Changes at arbitrary points mid-row; the model applies them per row.
        for (int i = 0; i < 2 * FP; i++) begin
            if ($urandom_range(0, 6) == 0) brightness = 2'($urandom_range(0, 3));
            @(negedge clk);
            got  = {row, col, fs, ack, col_n};
            want = {exp_row, exp_col, exp_fs, exp_ack, ~exp_col};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL brightness_mid cyc=%0d: got=%h required=%h", i, got, want);
            end
        end
        brightness = 2'd3;
    endtask

    task automatic test_collision();
        int acks = 0;
        int seen = 0;
        wait_frame("collision");
        for (int i = 0; i < 2 * FP; i++) begin
            swap_req = (i == 5 || i == 30);
            wr_en    = (i >= 10 && i <= 12) || (i == FP - 1);
            wr_row   = (i == FP - 1) ? 2'd0 : 2'(i - 9);
            wr_data  = (i == FP - 1) ? 4'hF : 4'($urandom_range(0, 15));
            @(negedge clk);
            got  = {row, col, fs, ack, col_n};
            want = {exp_row, exp_col, exp_fs, exp_ack, ~exp_col};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL collision cyc=%0d: got=%h required=%h", i, got, want);
            end
            if (ack === 1'b1) acks++;
            if (i >= FP && row === 2'd0 && col === 4'hF) seen++;
        end
        wr_en = 1'b0; swap_req = 1'b0;
        checks++;
        if (acks != 1) begin
            failures++;
            $display("FAIL collision_ack_count: got %0d required 1", acks);
        end
        checks++;
        if (seen != DWELL) begin
            failures++;
            $display("FAIL collision_row0: got %0d cycles of f on row 0 required %0d", seen, DWELL);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6 * FP; i++) begin
            wr_en    = 1'($urandom_range(0, 1));
            wr_row   = 2'($urandom_range(0, 3));
            wr_data  = 4'($urandom_range(0, 15));
            swap_req = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 30) == 0) brightness = 2'($urandom_range(0, 3));
            @(negedge clk);
            got  = {row, col, fs, ack, col_n};
            want = {exp_row, exp_col, exp_fs, exp_ack, ~exp_col};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL random cyc=%0d: got=%h required=%h", i, got, want);
            end
        end
        wr_en = 1'b0; swap_req = 1'b0; brightness = 2'd3;
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        int lit = 0;
        wait_frame("reset_mid");
        for (int i = 0; i < 2 * RP + 5; i++) begin
            swap_req = (i == 0);
            wr_en    = (i == 3);
            wr_row   = 2'd1;
            wr_data  = 4'h5;
            @(negedge clk);
        end
        wr_en = 1'b0; swap_req = 1'b0;
        checks++;
        if (row !== 2'd2 || col === 4'h0) begin
            failures++;
            $display("FAIL reset_mid_setup: got row=%0d col=%h required row=2 lit", row, col);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({row, col, fs, ack, col_n} !== 15'h000F) begin
            failures++;
            $display("FAIL reset_mid_state: got row=%0d col=%h fs=%b ack=%b coln=%h required 0/0/0/0/f", row, col, fs, ack, col_n);
        end
        rst_n = 1'b1;
        for (int i = 0; i < FP + RP; i++) begin
            @(negedge clk);
            got  = {row, col, fs, ack, col_n};
            want = {exp_row, exp_col, exp_fs, exp_ack, ~exp_col};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL reset_mid cyc=%0d: got=%h required=%h", i, got, want);
            end
            if (ack === 1'b1) acks++;
            if (col !== 4'h0) lit++;
        end
        checks++;
        if (acks != 0 || lit != 0) begin
            failures++;
            $display("FAIL reset_mid_cleared: got acks=%0d lit=%0d required 0/0", acks, lit);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_swap();
        test_brightness();
        test_collision();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
